// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared definitions for the two-source mux arbiter.
//   - arbiter state encoding (2 bits)
//   - mux select values for source A and source B
//   - widths of the burst counter and the optional transfer counters
package mux_arb_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned BURST_W = 8;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'b00,
    GRANT_A = 2'b01,
    GRANT_B = 2'b10
  } arb_state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_out_stage.sv
// mux_out_stage: single-entry valid/ready output register behind the mux.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   load_i          a source word is accepted this cycle (capture data_i)
//   data_i          mux output to capture
//   out_ready_i     consumer accepts the held word
//   out_valid_o     held word present
//   out_data_o      held word
//   load_ok_o       stage can take a new word this cycle
module mux_out_stage
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             load_ok_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Empty, or the held word leaves on this edge.
  assign load_ok_o = !valid_q || out_ready_i;

  // A load refills the entry even if the old word drains on the same edge.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin arbiter with per-grant burst limit sharing a 2:1
// datapath mux between source A (input 0) and source B (input 1), followed by
// a single-entry registered output stage.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   a_data/a_valid/a_ready     source A handshake
//   b_data/b_valid/b_ready     source B handshake
//   selector                   mux select (0 = A, 1 = B)
//   out_data/out_valid/out_ready  consumer handshake
// Optional (MUX_ARBITER_STATS_EN):
//   stats_clear                synchronous clear of both counters (wins over a transfer)
//   a_count, b_count           accepted-transfer counters, wrap at 2^16
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic             selector,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef MUX_ARBITER_STATS_EN
  ,
  input  logic             stats_clear,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
`endif
);

  localparam logic [BURST_W-1:0] MAX_BURST_C = BURST_W'(MAX_BURST);

  arb_state_e         state_q, state_d;
  logic               selector_q, selector_d;
  logic               last_q, last_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] burst_inc;
  logic               burst_done;
  logic               load_ok;
  logic               xfer_a, xfer_b;
  logic [WIDTH-1:0]   mux_data_c;

  // Handshake with the sources; only the granted side can see ready.
  assign a_ready    = (state_q == GRANT_A) && load_ok;
  assign b_ready    = (state_q == GRANT_B) && load_ok;
  assign xfer_a     = a_valid && a_ready;
  assign xfer_b     = b_valid && b_ready;
  assign burst_inc  = burst_q + BURST_W'(1);
  assign burst_done = (burst_inc == MAX_BURST_C);

  // Two-input datapath mux.
  assign mux_data_c = (selector_q == SEL_B) ? b_data : a_data;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      selector_q <= SEL_A;
      last_q     <= SEL_B;
      burst_q    <= '0;
    end else begin
      state_q    <= state_d;
      selector_q <= selector_d;
      last_q     <= last_d;
      burst_q    <= burst_d;
    end
  end

  // Next-state: a tie in IDLE goes to whoever was not served last.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (a_valid && b_valid) begin
          state_d = (last_q == SEL_A) ? GRANT_B : GRANT_A;
        end else if (a_valid) begin
          state_d = GRANT_A;
        end else if (b_valid) begin
          state_d = GRANT_B;
        end
      end
      GRANT_A: begin
        if (!a_valid) begin
          state_d = IDLE;
        end else if (xfer_a && burst_done && b_valid) begin
          state_d = GRANT_B;
        end
      end
      GRANT_B: begin
        if (!b_valid) begin
          state_d = IDLE;
        end else if (xfer_b && burst_done && a_valid) begin
          state_d = GRANT_A;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant bookkeeping: entering a grant loads selector/last_served and
  // restarts the burst; a burst that hits the limit without a switch restarts.
  always_comb begin
    selector_d = selector_q;
    last_d     = last_q;
    burst_d    = burst_q;
    if ((state_d != state_q) && (state_d != IDLE)) begin
      selector_d = (state_d == GRANT_B) ? SEL_B : SEL_A;
      last_d     = selector_d;
      burst_d    = '0;
    end else if ((state_d == state_q) && (xfer_a || xfer_b)) begin
      burst_d = burst_done ? '0 : burst_inc;
    end
  end

  mux_out_stage #(
    .WIDTH(WIDTH)
  ) u_out_stage (
    .clk        (clk),
    .reset      (reset),
    .load_i     (xfer_a || xfer_b),
    .data_i     (mux_data_c),
    .out_ready_i(out_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .load_ok_o  (load_ok)
  );

  assign selector = selector_q;

`ifdef MUX_ARBITER_STATS_EN
  logic [CNT_W-1:0] a_count_q, b_count_q;

  // Accepted-transfer counters; clear takes priority over a same-cycle transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_count_q <= '0;
      b_count_q <= '0;
    end else if (stats_clear) begin
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      if (xfer_a) a_count_q <= a_count_q + CNT_W'(1);
      if (xfer_b) b_count_q <= b_count_q + CNT_W'(1);
    end
  end

  assign a_count = a_count_q;
  assign b_count = b_count_q;
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: randomized and directed stimulus for mux_arbiter, with a
// transaction-level reference model feeding a scoreboard queue and an
// independent output monitor.
module tb_mux_arbiter;

  localparam int unsigned W    = 32;
  localparam int unsigned MAXB = 4;

  logic          clk;
  logic          reset;
  logic [W-1:0]  a_data, b_data, out_data;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic          selector, out_valid, out_ready;
`ifdef MUX_ARBITER_STATS_EN
  logic          stats_clear;
  logic [15:0]   a_count, b_count;
`endif

  mux_arbiter #(.WIDTH(W), .MAX_BURST(MAXB)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .selector (selector),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef MUX_ARBITER_STATS_EN
    ,
    .stats_clear(stats_clear),
    .a_count    (a_count),
    .b_count    (b_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus knobs (percent chance of asserting per cycle).
  int unsigned a_pct = 0, b_pct = 0, or_pct = 100, clr_pct = 0;
  bit          rnd_data = 1'b0;
  logic [W-1:0] a_next = '0, b_next = '0;
  bit          a_hold = 1'b0, b_hold = 1'b0;

  // Reference model state: owner 0=none 1=A 2=B.
  int          m_grant, m_last, m_cnt;
  bit          m_sel, m_full, m_xa;
  logic [15:0] m_acnt, m_bcnt;

  logic [W-1:0] sb[$];
  logic [W-1:0] obs[$];
  int           obs_cyc[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_init();
    m_grant = 0; m_last = 2; m_cnt = 0; m_sel = 1'b0; m_full = 1'b0; m_xa = 1'b0;
    m_acnt = '0; m_bcnt = '0;
    a_hold = 1'b0; b_hold = 1'b0;
  endtask

  // One cycle of the arbitration rules, evaluated with this cycle's inputs.
  task automatic model();
    bit lok, ear, ebr, xa, xb, mine, oth;
    int nxt;
    lok = !m_full || out_ready;
    ear = (m_grant == 1) && lok;
    ebr = (m_grant == 2) && lok;
    chk("a_ready", 32'(a_ready), 32'(ear));
    chk("b_ready", 32'(b_ready), 32'(ebr));
    chk("selector", 32'(selector), 32'(m_sel));
    chk("out_valid", 32'(out_valid), 32'(m_full));
`ifdef MUX_ARBITER_STATS_EN
    chk("a_count", 32'(a_count), 32'(m_acnt));
    chk("b_count", 32'(b_count), 32'(m_bcnt));
`endif
    xa = a_valid && ear;
    xb = b_valid && ebr;
    m_xa = xa;
    if (xa) sb.push_back(a_data);
    if (xb) sb.push_back(b_data);
`ifdef MUX_ARBITER_STATS_EN
    if (stats_clear) begin
      m_acnt = '0; m_bcnt = '0;
    end else begin
      if (xa) m_acnt = m_acnt + 16'd1;
      if (xb) m_bcnt = m_bcnt + 16'd1;
    end
`endif
    m_full = xa || xb || (m_full && !out_ready);
    if (m_grant == 0) begin
      nxt = 0;
      if (a_valid && b_valid) nxt = (m_last == 1) ? 2 : 1;
      else if (a_valid)       nxt = 1;
      else if (b_valid)       nxt = 2;
      if (nxt != 0) begin
        m_grant = nxt; m_sel = (nxt == 2); m_last = nxt; m_cnt = 0;
      end
    end else begin
      mine = (m_grant == 1) ? a_valid : b_valid;
      oth  = (m_grant == 1) ? b_valid : a_valid;
      if (!mine) begin
        m_grant = 0;
      end else if (xa || xb) begin
        m_cnt++;
        if (m_cnt == int'(MAXB)) begin
          m_cnt = 0;
          if (oth) begin
            m_grant = 3 - m_grant; m_sel = (m_grant == 2); m_last = m_grant;
          end
        end
      end
    end
    a_hold = a_valid && !xa;
    b_hold = b_valid && !xb;
    if (xa) a_next = rnd_data ? W'($urandom) : a_next + W'(1);
    if (xb) b_next = rnd_data ? W'($urandom) : b_next + W'(1);
  endtask

  // Drive one cycle of inputs at the falling edge, then run the model.
  task automatic step();
    @(negedge clk);
    if (!a_hold) begin
      a_valid = ($urandom_range(99) < a_pct);
      a_data  = a_next;
    end
    if (!b_hold) begin
      b_valid = ($urandom_range(99) < b_pct);
      b_data  = b_next;
    end
    out_ready = ($urandom_range(99) < or_pct);
`ifdef MUX_ARBITER_STATS_EN
    stats_clear = ($urandom_range(99) < clr_pct);
`endif
    #1;
    model();
  endtask

  task automatic finish_reset();
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
`ifdef MUX_ARBITER_STATS_EN
    stats_clear = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_init();
    sb.delete(); obs.delete(); obs_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    finish_reset();
  endtask

  // Monitor: consumer takes a word whenever valid and ready meet at an edge.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", out_data, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e);
        end
        obs.push_back(out_data);
        obs_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rr_exp [12];
    rr_exp = '{100, 101, 102, 103, 200, 201, 202, 203, 104, 105, 106, 107};
    reset = 1'b1;
    a_data = '0; b_data = '0;
    finish_reset();

    // Reset values.
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_selector", 32'(selector), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);

    // Single requester latency.
    a_pct = 100; b_pct = 0; or_pct = 100; a_next = 100; b_next = 200;
    step(); chk("single_n_aready", 32'(a_ready), 32'd0);
    step(); chk("single_n1_aready", 32'(a_ready), 32'd1);
            chk("single_n1_sel", 32'(selector), 32'd0);
    step(); chk("single_n2_data", out_data, 32'd100);
            chk("single_n2_valid", 32'(out_valid), 32'd1);
            chk("single_n2_sel", 32'(selector), 32'd0);
    a_pct = 0;
    repeat (4) step();

    // Async reset with a held word while B owns the mux.
    do_reset();
    a_pct = 0; b_pct = 100; or_pct = 0; b_next = 200;
    repeat (3) step();
    @(posedge clk); #2;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_sel", 32'(selector), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", out_data, 32'd0);
    chk("async_rst_sel", 32'(selector), 32'd0);
    finish_reset();

    // First tie after reset goes to A, then round robin with burst limit.
    a_pct = 100; b_pct = 100; or_pct = 100; a_next = 100; b_next = 200;
    step(); step();
    chk("tie_a_first", 32'(a_ready), 32'd1);
    chk("tie_b_wait", 32'(b_ready), 32'd0);
    repeat (16) step();
    chk("rr_count", 32'(obs.size() >= 12), 32'd1);
    if (obs.size() >= 12) begin
      for (int i = 0; i < 12; i++) chk($sformatf("rr_word%0d", i), obs[i], rr_exp[i]);
      chk("rr_no_bubble", 32'(obs_cyc[11] - obs_cyc[0]), 32'd11);
    end
    a_pct = 0; b_pct = 0;
    repeat (6) step();

    // Backpressure inside a B burst.
    do_reset();
    a_pct = 0; b_pct = 100; or_pct = 100; b_next = 200;
    step(); step();
    or_pct = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_data", out_data, 32'd200);
      chk("bp_bready", 32'(b_ready), 32'd0);
    end
    or_pct = 100;
    repeat (6) step();
    chk("bp_count", 32'(obs.size() >= 3), 32'd1);
    if (obs.size() >= 3) begin
      chk("bp_w0", obs[0], 32'd200);
      chk("bp_w1", obs[1], 32'd201);
      chk("bp_w2", obs[2], 32'd202);
    end
    b_pct = 0;
    repeat (6) step();

    // Grant release to IDLE, then a later B request.
    do_reset();
    a_pct = 100; b_pct = 0; or_pct = 100; a_next = 100; b_next = 300;
    step(); step(); step();
    a_pct = 0;
    step(); chk("rel_sel_hold", 32'(selector), 32'd0);
    step(); chk("rel_idle_aready", 32'(a_ready), 32'd0);
            chk("rel_idle_sel", 32'(selector), 32'd0);
    b_pct = 100;
    step(); chk("rel_b_arb", 32'(b_ready), 32'd0);
            chk("rel_b_arb_sel", 32'(selector), 32'd0);
    step(); chk("rel_b_grant", 32'(b_ready), 32'd1);
            chk("rel_b_grant_sel", 32'(selector), 32'd1);
    b_pct = 0;
    repeat (6) step();

`ifdef MUX_ARBITER_STATS_EN
    // Counters: 3 A then 2 B transfers, then clear coinciding with a transfer.
    do_reset();
    or_pct = 100; a_pct = 100; b_pct = 0;
    for (int i = 0; i < 20 && m_acnt != 16'd3; i++) step();
    a_pct = 0; b_pct = 100;
    for (int i = 0; i < 20 && m_bcnt != 16'd2; i++) step();
    b_pct = 0;
    repeat (4) step();
    chk("stats_a3", 32'(a_count), 32'd3);
    chk("stats_b2", 32'(b_count), 32'd2);
    a_pct = 100;
    for (int i = 0; i < 10; i++) begin
      clr_pct = (m_grant == 1) ? 100 : 0;
      step();
      if (m_xa) break;
    end
    clr_pct = 0; a_pct = 0;
    step();
    chk("stats_clear_wins", 32'(a_count), 32'd0);
    repeat (4) step();
`endif

    // Randomized traffic against the model.
    do_reset();
    rnd_data = 1'b1;
    a_next = $urandom; b_next = $urandom;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        a_pct   = $urandom_range(100);
        b_pct   = $urandom_range(100);
        or_pct  = $urandom_range(20, 100);
        clr_pct = $urandom_range(5);
      end
      step();
    end
    a_pct = 0; b_pct = 0; or_pct = 100; clr_pct = 0;
    repeat (12) step();
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
